// File: rtl/hmac_pkg.sv
// Shared definitions for the HMAC byte feeder: word geometry, tag width, FSM states.
package hmac_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned TAG_BITS   = 256;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_READY,
        PACK,
        FINAL,
        WAIT_HASH
    } feeder_state_t;

endpackage

// File: rtl/hmac_byte_feeder.sv
// Packs a byte stream into big-endian 32-bit words for a streaming HMAC-SHA256 core
// and captures the resulting tag together with the message byte count.
module hmac_byte_feeder
    import hmac_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,

    output logic                  hmac_start,
    input  logic                  hmac_ready,
    output logic                  hmac_update,
    output logic [31:0]           hmac_data,
    output logic [2:0]            hmac_bytes_valid,
    output logic                  hmac_finalize,
    input  logic                  hmac_hash_valid,
    input  logic [TAG_BITS-1:0]   hmac_hash,

    output logic                  tag_valid,
    output logic [TAG_BITS-1:0]   tag,
    output logic [LEN_WIDTH-1:0]  msg_len,
    output logic                  busy
);

    feeder_state_t         state;
    logic [1:0]            lane;
    logic [31:0]           word_buf;
    logic [31:0]           word_next;
    logic [LEN_WIDTH-1:0]  len_cnt;
    logic                  accept;

    assign s_ready = (state == PACK);
    assign busy    = (state != IDLE);
    assign accept  = s_valid && s_ready;

    // Lane 0 starts a fresh word so stale bytes never leak into unused low lanes.
    always_comb begin
        word_next = (lane == 2'd0) ? '0 : word_buf;
        case (lane)
            2'd0:    word_next[31:24] = s_data;
            2'd1:    word_next[23:16] = s_data;
            2'd2:    word_next[15:8]  = s_data;
            default: word_next[7:0]   = s_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lane             <= '0;
            word_buf         <= '0;
            len_cnt          <= '0;
            hmac_start       <= 1'b0;
            hmac_update      <= 1'b0;
            hmac_data        <= '0;
            hmac_bytes_valid <= '0;
            hmac_finalize    <= 1'b0;
            tag_valid        <= 1'b0;
            tag              <= '0;
            msg_len          <= '0;
        end else begin
            hmac_start    <= 1'b0;
            hmac_update   <= 1'b0;
            hmac_finalize <= 1'b0;
            tag_valid     <= 1'b0;

            case (state)
                // Holding off while tag_valid is high guarantees an idle cycle before the next start.
                IDLE: begin
                    if (s_valid && !tag_valid) begin
                        state      <= START;
                        hmac_start <= 1'b1;
                    end
                end
                START: begin
                    len_cnt <= '0;
                    lane    <= '0;
                    state   <= WAIT_READY;
                end
                WAIT_READY: begin
                    if (hmac_ready) begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    if (accept) begin
                        word_buf <= word_next;
                        if (len_cnt != '1) begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                        if (lane == 2'd3 || s_last) begin
                            hmac_update      <= 1'b1;
                            hmac_data        <= word_next;
                            hmac_bytes_valid <= {1'b0, lane} + 3'd1;
                            lane             <= '0;
                        end else begin
                            lane <= lane + 2'd1;
                        end
                        if (s_last) begin
                            state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    hmac_finalize <= 1'b1;
                    state         <= WAIT_HASH;
                end
                WAIT_HASH: begin
                    if (hmac_hash_valid) begin
                        tag       <= hmac_hash;
                        msg_len   <= len_cnt;
                        tag_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hmac_byte_feeder.sv
// Directed bench for hmac_byte_feeder with a behavioural stand-in for the HMAC core.
module tb_hmac_byte_feeder;

    typedef struct {
        logic [159:0] msg;
        int unsigned  len;
        int unsigned  delay;
        logic [255:0] tag;
        logic [15:0]  len16;
        logic [3:0]   len4;
        int unsigned  nupd;
        logic [31:0]  first_w;
        logic [31:0]  last_w;
        logic [2:0]   last_bv;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic [7:0]   s_data = '0;
    logic         s_last = 1'b0;
    logic         s_ready, hmac_start, hmac_update, hmac_finalize, tag_valid, busy;
    logic [31:0]  hmac_data;
    logic [2:0]   hmac_bytes_valid;
    logic [255:0] tag;
    logic [15:0]  msg_len;
    logic         d4_s_ready, d4_start, d4_update, d4_finalize, d4_tag_valid, d4_busy;
    logic [31:0]  d4_data;
    logic [2:0]   d4_bv;
    logic [255:0] d4_tag;
    logic [3:0]   d4_msg_len;

    logic         hmac_ready = 1'b1;
    logic         core_hv = 1'b0;
    logic [255:0] core_hash = '0;
    logic         spur_hv = 1'b0;
    logic         hmac_hash_valid;
    logic [255:0] hmac_hash;
    int unsigned  hold = 0;
    int unsigned  hash_wait = 0;
    int unsigned  ready_delay = 0;
    logic [255:0] cur_tag = '0;

    int unsigned  tests = 0;
    int unsigned  failed = 0;

    int unsigned  upd_cnt = 0, fin_cnt = 0, fin_bad = 0, start_cnt = 0;
    int unsigned  rdy_bad = 0, tagv_cnt = 0, gap_bad = 0;
    logic         prev_upd = 1'b0, prev_tagv = 1'b0;
    logic [31:0]  rec_data [64];
    logic [2:0]   rec_bv [64];

    vec_t vecs [8];

    assign hmac_hash_valid = core_hv | spur_hv;
    assign hmac_hash       = spur_hv ? {8{32'hdeadbeef}} : core_hash;

    always #5 clk = ~clk;

    hmac_byte_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .hmac_start(hmac_start), .hmac_ready(hmac_ready), .hmac_update(hmac_update),
        .hmac_data(hmac_data), .hmac_bytes_valid(hmac_bytes_valid), .hmac_finalize(hmac_finalize),
        .hmac_hash_valid(hmac_hash_valid), .hmac_hash(hmac_hash),
        .tag_valid(tag_valid), .tag(tag), .msg_len(msg_len), .busy(busy)
    );

    hmac_byte_feeder #(.LEN_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(d4_s_ready), .s_data(s_data), .s_last(s_last),
        .hmac_start(d4_start), .hmac_ready(hmac_ready), .hmac_update(d4_update),
        .hmac_data(d4_data), .hmac_bytes_valid(d4_bv), .hmac_finalize(d4_finalize),
        .hmac_hash_valid(hmac_hash_valid), .hmac_hash(hmac_hash),
        .tag_valid(d4_tag_valid), .tag(d4_tag), .msg_len(d4_msg_len), .busy(d4_busy)
    );

    // Core stand-in: ready drops for ready_delay cycles after start, hash returns 3 cycles after finalize.
    always @(posedge clk) begin
        core_hv <= 1'b0;
        if (hmac_start) begin
            hold       <= ready_delay;
            hmac_ready <= (ready_delay == 0);
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) hmac_ready <= 1'b1;
        end
        if (hmac_finalize) begin
            hash_wait <= 3;
        end else if (hash_wait != 0) begin
            hash_wait <= hash_wait - 1;
            if (hash_wait == 1) begin
                core_hv   <= 1'b1;
                core_hash <= cur_tag;
            end
        end
    end

    always @(negedge clk) begin
        if (hmac_update) begin
            rec_data[upd_cnt % 64] = hmac_data;
            rec_bv[upd_cnt % 64]   = hmac_bytes_valid;
            upd_cnt = upd_cnt + 1;
        end
        if (hmac_finalize) begin
            fin_cnt = fin_cnt + 1;
            if (!prev_upd) fin_bad = fin_bad + 1;
        end
        if (hmac_start) begin
            start_cnt = start_cnt + 1;
            if (prev_tagv) gap_bad = gap_bad + 1;
        end
        if (!hmac_ready && s_ready) rdy_bad = rdy_bad + 1;
        if (tag_valid) tagv_cnt = tagv_cnt + 1;
        prev_upd  = hmac_update;
        prev_tagv = tag_valid;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [159:0] m, input int unsigned i);
        return m[159 - 8*i -: 8];
    endfunction

    function automatic vec_t mk(input logic [159:0] msg, input int unsigned len, input int unsigned delay,
                                input logic [255:0] t, input logic [15:0] l16, input logic [3:0] l4,
                                input int unsigned nupd, input logic [31:0] fw, input logic [31:0] lw,
                                input logic [2:0] lbv);
        vec_t v;
        v.msg = msg; v.len = len; v.delay = delay; v.tag = t; v.len16 = l16; v.len4 = l4;
        v.nupd = nupd; v.first_w = fw; v.last_w = lw; v.last_bv = lbv;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        int unsigned ub, fb, sb, rb, tb0, gb, i, budget, werr, k;
        logic acc, got;
        logic [31:0] ew;
        logic [2:0]  ebv;
        ub = upd_cnt; fb = fin_cnt; sb = start_cnt; rb = rdy_bad; tb0 = tagv_cnt; gb = gap_bad;
        cur_tag = v.tag;
        ready_delay = v.delay;
        i = 0; budget = 0;
        while (i < v.len && budget < 400) begin
            s_valid = 1'b1;
            s_data  = byte_at(v.msg, i);
            s_last  = (i == v.len - 1);
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) i = i + 1;
            budget = budget + 1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("bytes_accepted", i, v.len);

        got = 1'b0; budget = 0;
        while (!got && budget < 100) begin
            @(negedge clk);
            if (tag_valid) got = 1'b1;
            budget = budget + 1;
        end
        chk("tag_valid_seen", got, 1'b1);
        chk("tag", tag, v.tag);
        chk("msg_len", msg_len, v.len16);
        chk("msg_len_w4", d4_msg_len, v.len4);
        @(negedge clk);
        #1;
        chk("tag_valid_one_cycle", tag_valid, 1'b0);
        chk("tag_held", tag, v.tag);
        chk("update_count", upd_cnt - ub, v.nupd);
        chk("first_word", rec_data[ub % 64], v.first_w);
        chk("last_word", rec_data[(upd_cnt - 1) % 64], v.last_w);
        chk("last_bytes_valid", rec_bv[(upd_cnt - 1) % 64], v.last_bv);
        chk("finalize_count", fin_cnt - fb, 1);
        chk("finalize_after_update", fin_bad, 0);
        chk("start_count", start_cnt - sb, 1);
        chk("tag_valid_count", tagv_cnt - tb0, 1);
        chk("s_ready_while_core_busy", rdy_bad - rb, 0);
        chk("idle_gap_before_start", gap_bad - gb, 0);
        werr = 0;
        for (k = 0; k < upd_cnt - ub; k++) begin
            ew = '0;
            for (int j = 0; j < 4; j++)
                if (4*k + j < v.len) ew[31 - 8*j -: 8] = byte_at(v.msg, 4*k + j);
            ebv = (v.len - 4*k >= 4) ? 3'd4 : 3'(v.len - 4*k);
            if (rec_data[(ub + k) % 64] !== ew || rec_bv[(ub + k) % 64] !== ebv) werr = werr + 1;
        end
        chk("packed_words", werr, 0);
    endtask

    initial begin
        int unsigned i, budget, fb;
        logic acc;

        vecs[0] = mk({40'h6162636465, 120'h0}, 5, 0, {8{32'h11111111}}, 16'd5, 4'd5, 2,
                     32'h61626364, 32'h65000000, 3'd1);
        vecs[1] = mk({64'h4869205468657265, 96'h0}, 8, 5,
                     256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7,
                     16'd8, 4'd8, 2, 32'h48692054, 32'h68657265, 3'd4);
        vecs[2] = mk({32'h61626364, 128'h0}, 4, 0, {8{32'h22222222}}, 16'd4, 4'd4, 1,
                     32'h61626364, 32'h61626364, 3'd4);
        vecs[3] = mk({32'h7778797a, 128'h0}, 4, 0, {8{32'h33333333}}, 16'd4, 4'd4, 1,
                     32'h7778797a, 32'h7778797a, 3'd4);
        vecs[4] = mk(160'h000102030405060708090a0b0c0d0e0f10111213, 20, 2, {8{32'h44444444}},
                     16'd20, 4'd15, 5, 32'h00010203, 32'h10111213, 3'd4);
        vecs[5] = mk({8'ha5, 152'h0}, 1, 0, {8{32'h55555555}}, 16'd1, 4'd1, 1,
                     32'ha5000000, 32'ha5000000, 3'd1);
        vecs[6] = mk({48'h414243444546, 112'h0}, 6, 1, {8{32'h66666666}}, 16'd6, 4'd6, 2,
                     32'h41424344, 32'h45460000, 3'd2);
        vecs[7] = mk({56'h01020304050607, 104'h0}, 7, 0, {8{32'h77777777}}, 16'd7, 4'd7, 2,
                     32'h01020304, 32'h05060700, 3'd3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", |{s_ready, hmac_start, hmac_update, hmac_data, hmac_bytes_valid,
                                    hmac_finalize, tag_valid, tag, msg_len, busy}, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_not_busy", busy, 1'b0);

        for (int n = 0; n < 8; n++) apply(vecs[n]);

        // Spurious hash outside WAIT_HASH must not disturb the held tag.
        @(posedge clk); #1 spur_hv = 1'b1;
        @(posedge clk); #1 spur_hv = 1'b0;
        @(negedge clk);
        chk("spurious_hash_no_tag_valid", tag_valid, 1'b0);
        chk("spurious_hash_tag_held", tag, vecs[7].tag);
        chk("spurious_hash_len_held", msg_len, 16'd7);

        // Abandon a message after 3 bytes with a reset pulse.
        fb = fin_cnt;
        ready_delay = 0;
        i = 0; budget = 0;
        while (i < 3 && budget < 100) begin
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(i);
            s_last  = 1'b0;
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) i = i + 1;
            budget = budget + 1;
        end
        chk("abort_bytes_accepted", i, 3);
        rst_n = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("midmsg_reset_outputs_zero", |{s_ready, hmac_start, hmac_update, hmac_data, hmac_bytes_valid,
                                           hmac_finalize, tag_valid, tag, msg_len, busy}, 1'b0);
        chk("midmsg_reset_w4_len_zero", d4_msg_len, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_finalize", fin_cnt - fb, 0);
        chk("abort_idle", busy, 1'b0);

        apply(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hmac_byte_feeder.md
HMAC_BYTE_FEEDER -- requirements
Module: hmac_byte_feeder

Interface
Parameters:
REQ-001 The block SHALL have parameter LEN_WIDTH, default 16, giving the width of the reported message byte count.
Ports:
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port s_valid, input, 1, upstream byte valid.
REQ-005 The block SHALL have port s_ready, output, 1, upstream byte accept.
REQ-006 The block SHALL have port s_data, input, 8, the message byte.
REQ-007 The block SHALL have port s_last, input, 1, which marks the final byte of a message.
REQ-008 The block SHALL have ports hmac_start (output, 1), hmac_ready (input, 1), hmac_update (output, 1), hmac_data (output, 32), hmac_bytes_valid (output, 3) and hmac_finalize (output, 1), all driving the streaming HMAC-SHA256 core.
REQ-009 The block SHALL have ports hmac_hash_valid (input, 1) and hmac_hash (input, 256), the result from the core.
REQ-010 The block SHALL have ports tag_valid (output, 1), tag (output, 256) and msg_len (output, LEN_WIDTH), the completed MAC and its byte count.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The block SHALL implement the states IDLE, START, WAIT_READY, PACK, FINAL and WAIT_HASH.
REQ-013 IDLE: s_ready SHALL be 0; s_valid=1 moves the state to START without consuming the byte.
REQ-014 START: hmac_start SHALL be 1 for exactly one cycle, the length counter SHALL be cleared, and the state then moves to WAIT_READY.
REQ-015 WAIT_READY: s_ready SHALL be 0, and the state SHALL move to PACK on the first cycle with hmac_ready=1; the block SHALL NOT sample hmac_ready in the same cycle as the start pulse.
REQ-016 PACK: s_ready SHALL be 1, and a byte is consumed on s_valid&&s_ready.
REQ-017 Packing SHALL be big-endian: byte 0 goes to hmac_data[31:24] and byte 3 to hmac_data[7:0].
REQ-018 Each accepted byte SHALL increment a 2-bit lane counter.
REQ-019 When the 4th byte of a word is accepted, or s_last is accepted, the block SHALL assert registered hmac_update for one cycle on the next cycle, with hmac_bytes_valid equal to the number of bytes (1..4), unused low lanes zero, and the lane counter cleared.
REQ-020 If the 4th byte and s_last arrive together, the block SHALL issue one update with bytes_valid=4 and no extra empty word.
REQ-021 Updates SHALL be issuable on consecutive cycles; the block SHALL NOT sample hmac_ready during PACK.
REQ-022 Acceptance of s_last SHALL move the state to FINAL; s_ready SHALL be 0 from the following cycle.
REQ-023 FINAL: hmac_finalize SHALL be 1 for exactly one cycle, the cycle after the last update, and the state then moves to WAIT_HASH.
REQ-024 WAIT_HASH: on hmac_hash_valid=1 the block SHALL latch hmac_hash into tag, pulse tag_valid for one cycle, and return to IDLE.
REQ-025 tag and msg_len SHALL hold their values until the next completed message.
REQ-026 msg_len SHALL count the accepted bytes of the message and saturate at 2^LEN_WIDTH-1; hashing continues unaffected past saturation.
REQ-027 Messages SHALL be at least 1 byte; zero-length messages are not expressible.
REQ-028 hmac_data and hmac_bytes_valid SHALL be don't-care when hmac_update=0 but SHALL NOT change while hmac_update=1.
REQ-029 A new message SHALL begin only from IDLE; at least 1 idle cycle SHALL occur between tag_valid and the next hmac_start.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously enter IDLE and clear the lane and length counters.
REQ-031 On rst_n low, all outputs including tag and msg_len SHALL be 0.
REQ-032 Reset mid-message SHALL abandon the message without issuing finalize; the core is not reset and is reinitialised by the next hmac_start.
REQ-033 hmac_hash_valid arriving outside WAIT_HASH SHALL be ignored.

Structure
REQ-034 The state enum and constants WORD_BYTES=4 and TAG_BITS=256 SHALL reside in shared package hmac_pkg.
REQ-035 The block SHALL have no sub-module; the HMAC core is instantiated alongside the block by the parent.

Verification
REQ-036 "Hi There" (8 bytes, last on 'e') with the core and key 20x0b -> updates "Hi T"/4 then "here"/4, finalize, and tag=b0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7 with msg_len=8.
REQ-037 "abcde" -> updates 61626364/4 then 65000000/1, then finalize on the next cycle.
REQ-038 Core model holds hmac_ready=0 for 5 cycles after start -> s_ready stays 0 for those cycles and no byte is lost.
REQ-039 rst_n pulsed after 3 bytes, then "Hi There" -> no finalize before reset, outputs all 0 during reset, and the correct tag for REQ-036's message afterwards.
REQ-040 Two back-to-back 4-byte messages -> two hmac_start pulses and two tag_valid pulses, each with msg_len=4.
REQ-041 LEN_WIDTH=4 with a 20-byte message -> msg_len=15, 5 updates of bytes_valid=4, and one finalize.
